// File: rtl/control_desplazamiento_pkg.sv
// Shared ALU constants for the multi-pass shift sequencer.
// State encoding and pass limits used by control_desplazamiento.
package control_desplazamiento_pkg;

  localparam int ANCHO_DATO = 8;
  localparam int PASO_MAX   = 7;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    DESPLAZA = 2'd1,
    LISTO    = 2'd2
  } estado_t;

endpackage

// File: rtl/control_desplazamiento.sv
// Splits a left shift of up to 2^ANCHO_CANT-1 bits into passes of
// at most PASO_MAX bits through an external combinational shifter.
module control_desplazamiento
  import control_desplazamiento_pkg::*;
#(
  parameter int ANCHO_CANT = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valido,
  output logic                  in_listo,
  input  logic [7:0]            dato_in,
  input  logic [ANCHO_CANT-1:0] cant_in,
  output logic [7:0]            sh_valor,
  output logic [2:0]            sh_cant,
  input  logic [7:0]            sh_resultado,
  output logic                  out_valido,
  input  logic                  out_listo,
  output logic [7:0]            dato_out,
  output logic                  cero,
  output logic                  acarreo,
  output logic                  ocupado
);

  estado_t               estado, estado_sig;
  logic [7:0]            valor;
  logic [ANCHO_CANT-1:0] resto;
  logic [ANCHO_CANT-1:0] resto_sig;
  logic                  acarreo_q;
  logic [2:0]            paso;
  logic [3:0]            idx;
  logic                  saliente;

  // Step size: min(resto, PASO_MAX); ANCHO_CANT is assumed >= 3.
  always_comb begin
    paso = resto[2:0];
    if (resto > ANCHO_CANT'(PASO_MAX))
      paso = 3'(PASO_MAX);
  end

  assign resto_sig = resto - ANCHO_CANT'(paso);
  assign idx       = 4'(ANCHO_DATO) - {1'b0, paso};
  assign saliente  = valor[idx[2:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      estado <= ESPERA;
    else
      estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      ESPERA:
        if (in_valido)
          estado_sig = DESPLAZA;
      DESPLAZA:
        if (resto_sig == '0)
          estado_sig = LISTO;
      LISTO:
        if (out_listo)
          estado_sig = ESPERA;
      default:
        estado_sig = ESPERA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valor     <= '0;
      resto     <= '0;
      acarreo_q <= 1'b0;
    end else begin
      if (estado == ESPERA && in_valido) begin
        valor     <= dato_in;
        resto     <= cant_in;
        acarreo_q <= 1'b0;
      end else if (estado == DESPLAZA) begin
        valor <= sh_resultado;
        resto <= resto_sig;
        if (paso != 3'd0)
          acarreo_q <= saliente;
      end
    end
  end

  assign in_listo   = (estado == ESPERA);
  assign out_valido = (estado == LISTO);
  assign ocupado    = (estado != ESPERA);
  assign sh_valor   = (estado == DESPLAZA) ? valor : 8'd0;
  assign sh_cant    = (estado == DESPLAZA) ? paso : 3'd0;
  assign dato_out   = valor;
  assign cero       = (valor == 8'd0);
  assign acarreo    = acarreo_q;

endmodule
